// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. Owns the fetch program counter (fpc), reads the
// byte-addressed, big-endian instruction ROM one 32-bit word per cycle and
// holds the fetched word in an instruction register offered to decode with a
// valid/ready handshake. Handles redirects from later stages, a halt opcode,
// and misaligned/out-of-range fetch addresses, which end in a terminal fault.
//
// Ports:
//   clk            in   clock, rising edge
//   nrst           in   asynchronous active-low reset
//   romAddr        out  ROM byte address, always equal to fpc
//   romNrd         out  ROM read enable, active-low
//   romData        in   ROM word for romAddr, valid in the same cycle
//   instOut        out  registered instruction
//   pcOut          out  byte address of instOut
//   pcPlus4        out  pcOut + 4 (wraps mod 2^32)
//   instValid      out  instOut holds an unconsumed instruction
//   decReady       in   decode accepts instOut this cycle
//   redirect       in   next fetch address comes from redirectTarget
//   redirectTarget in   redirect byte address
//   halted         out  registered, high while halted
//   fault          out  registered, high after a bad fetch address
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int          ROM_BYTES   = 100,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        nrst,
    output logic [31:0] romAddr,
    output logic        romNrd,
    input  logic [31:0] romData,
    output logic [31:0] instOut,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    output logic        instValid,
    input  logic        decReady,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Highest byte address at which a whole word still fits in the ROM.
    localparam logic [31:0] LAST_ADDR = 32'(ROM_BYTES - 4);

    state_t      state, state_d;
    logic [31:0] fpc, fpc_d;
    logic [31:0] inst_d, pc_d;
    logic        valid_d;
    logic        fetch_ok;
    logic        load;

    // Unsigned compare: addresses near 2^32 are simply large, never valid.
    assign fetch_ok = (fpc[1:0] == 2'b00) && (fpc <= LAST_ADDR);
    assign load     = (state == RUN) && fetch_ok && (!instValid || decReady);

    assign romAddr  = fpc;
    assign romNrd   = !((state == RUN) && fetch_ok);
    assign pcPlus4  = pcOut + 32'd4;

    // Next-state logic. Branch order is the event priority:
    // redirect, fault entry, load/halt, drain.
    always_comb begin
        // NOTE: every signal gets a hold value first so no path leaves one
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state;
        fpc_d   = fpc;
        inst_d  = instOut;
        pc_d    = pcOut;
        valid_d = instValid;

        if (redirect && state != FAULT) begin
            // Flush only; the target is fetched on the following edge.
            state_d = RUN;
            fpc_d   = redirectTarget;
            valid_d = 1'b0;
        end else if (state == RUN && !fetch_ok) begin
            state_d = FAULT;
            if (decReady) valid_d = 1'b0;
        end else if (load) begin
            inst_d  = romData;
            pc_d    = fpc;
            valid_d = 1'b1;
            fpc_d   = fpc + 32'd4;
            // The halt word itself still goes to decode.
            if (romData[31:26] == HALT_OPCODE) state_d = HALT;
        end else if (decReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= RUN;
            fpc       <= RESET_PC;
            instOut   <= 32'h0;
            pcOut     <= 32'h0;
            instValid <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_d;
            fpc       <= fpc_d;
            instOut   <= inst_d;
            pcOut     <= pc_d;
            instValid <= valid_d;
            // Flags follow the state transition on the same edge.
            halted    <= (state_d == HALT);
            fault     <= (state_d == FAULT);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch: directed scenarios (sequential fetch,
// stall, redirect, halt, fault, asynchronous reset) followed by randomized
// episodes, all compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int ROM_BYTES = 100;
    localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] rom_addr, rom_data, inst_out, pc_out, pc_plus4, redirect_target;
    logic        rom_nrd, inst_valid, dec_ready, redirect, halted, fault;

    logic [7:0]  rom [0:ROM_BYTES-1];

    // Reference model state
    logic [31:0] m_fpc, m_inst, m_pc;
    logic        m_valid;
    int          m_mode;

    int n_checks = 0;
    int n_pass   = 0;

    inst_fetch #(
        .ROM_BYTES(ROM_BYTES), .RESET_PC(32'h0), .HALT_OPCODE(6'h3F)
    ) dut (
        .clk(clk), .nrst(nrst),
        .romAddr(rom_addr), .romNrd(rom_nrd), .romData(rom_data),
        .instOut(inst_out), .pcOut(pc_out), .pcPlus4(pc_plus4),
        .instValid(inst_valid), .decReady(dec_ready),
        .redirect(redirect), .redirectTarget(redirect_target),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Big-endian ROM, combinational read; addresses without a full word read 0.
    always_comb begin
        rom_data = 32'h0;
        if (rom_addr <= 32'd96)
            rom_data = {rom[rom_addr[6:0]], rom[rom_addr[6:0] + 7'd1],
                        rom[rom_addr[6:0] + 7'd2], rom[rom_addr[6:0] + 7'd3]};
    end

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] w;
        w = 32'h0;
        if (a <= 32'd96)
            w = {rom[a[6:0]], rom[a[6:0] + 7'd1], rom[a[6:0] + 7'd2], rom[a[6:0] + 7'd3]};
        return w;
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        rom[a]   = w[31:24];
        rom[a+1] = w[23:16];
        rom[a+2] = w[15:8];
        rom[a+3] = w[7:0];
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit m_fetch_ok();
        return (m_fpc % 4 == 0) && (m_fpc <= 32'(ROM_BYTES - 4));
    endfunction

    task automatic model_reset();
        m_fpc = 32'h0; m_inst = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_mode = M_RUN;
    endtask

    // One clock edge of the fetch stage, computed from the behavioural rules.
    task automatic model_step(input bit dr, input bit rd, input logic [31:0] tgt);
        logic [31:0] w;
        if (m_mode != M_FAULT && rd) begin
            m_fpc = tgt; m_valid = 1'b0; m_mode = M_RUN;
        end else if (m_mode == M_RUN && !m_fetch_ok()) begin
            m_mode = M_FAULT;
            if (dr) m_valid = 1'b0;
        end else if (m_mode == M_RUN && (!m_valid || dr)) begin
            w = rom_word(m_fpc);
            m_inst = w; m_pc = m_fpc; m_valid = 1'b1; m_fpc = m_fpc + 32'd4;
            if (w[31:26] == 6'h3F) m_mode = M_HALT;
        end else if (dr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("romAddr",   rom_addr,   m_fpc);
        check("romNrd",    {31'h0, rom_nrd}, {31'h0, !(m_mode == M_RUN && m_fetch_ok())});
        check("instValid", {31'h0, inst_valid}, {31'h0, m_valid});
        check("instOut",   inst_out,   m_inst);
        check("pcOut",     pc_out,     m_pc);
        check("pcPlus4",   pc_plus4,   m_pc + 32'd4);
        check("halted",    {31'h0, halted}, {31'h0, m_mode == M_HALT});
        check("fault",     {31'h0, fault},  {31'h0, m_mode == M_FAULT});
    endtask

    // Called at a falling edge: drive inputs, advance the model, then sample
    // at the next falling edge.
    task automatic cycle(input bit dr, input bit rd, input logic [31:0] tgt);
        dec_ready = dr; redirect = rd; redirect_target = tgt;
        model_step(dr, rd, tgt);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge; reset pulse stays clear of rising edges.
    task automatic reset_dut();
        dec_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        nrst = 1'b0;
        model_reset();
        #1;
        compare_all();
        #1;
        nrst = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_romAddr"},   rom_addr, 32'h0);
        check({tag, "_romNrd"},    {31'h0, rom_nrd}, 32'h0);
        check({tag, "_instValid"}, {31'h0, inst_valid}, 32'h0);
        check({tag, "_instOut"},   inst_out, 32'h0);
        check({tag, "_pcOut"},     pc_out, 32'h0);
        check({tag, "_pcPlus4"},   pc_plus4, 32'h4);
        check({tag, "_halted"},    {31'h0, halted}, 32'h0);
        check({tag, "_fault"},     {31'h0, fault}, 32'h0);
    endtask

    task automatic fill_directed_rom();
        for (int a = 0; a < ROM_BYTES; a += 4)
            put_word(a, {6'h08, 26'($urandom)});
        put_word(0,  32'h20010005);
        put_word(4,  32'h20020007);
        put_word(8,  32'h00221820);
        put_word(12, 32'hFC000000);
        put_word(16, 32'h12345678);
    endtask

    initial begin
        logic [31:0] tgt;
        int          sel;

        fill_directed_rom();

        // Reset values
        nrst = 1'b0; dec_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
        model_reset();
        #1;
        check_reset_values("reset");
        @(negedge clk);
        nrst = 1'b1;

        // Sequential fetch, one word per cycle
        cycle(1, 0, 0);
        check("seq0_inst", inst_out, 32'h20010005);
        check("seq0_pc4",  pc_plus4, 32'h4);
        cycle(1, 0, 0);
        check("seq1_inst", inst_out, 32'h20020007);
        cycle(1, 0, 0);
        check("seq2_inst", inst_out, 32'h00221820);
        check("seq2_pc",   pc_out,   32'h8);
        check("seq2_pc4",  pc_plus4, 32'hC);

        // Stall after the first load
        @(negedge clk);
        reset_dut();
        cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0);
            check("stall_inst", inst_out, 32'h20010005);
            check("stall_fpc",  rom_addr, 32'h4);
        end
        cycle(1, 0, 0);
        check("stall_release", inst_out, 32'h20020007);

        // Redirect while decode is stalled: one bubble, then the target
        cycle(0, 1, 32'h10);
        check("redir_bubble", {31'h0, inst_valid}, 32'h0);
        cycle(0, 0, 0);
        check("redir_inst", inst_out, 32'h12345678);
        check("redir_pc",   pc_out,   32'h10);

        // Halt word at 0xC
        cycle(1, 1, 32'h8);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("halt_inst",   inst_out, 32'hFC000000);
        check("halt_pc",     pc_out,   32'hC);
        check("halt_flag",   {31'h0, halted},  32'h1);
        check("halt_romNrd", {31'h0, rom_nrd}, 32'h1);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("halt_hold", {31'h0, halted}, 32'h1);
        cycle(0, 1, 32'h0);
        cycle(1, 0, 0);
        check("unhalt_inst", inst_out, 32'h20010005);
        check("unhalt_pc",   pc_out,   32'h0);

        // Sequential run off the end of the ROM
        cycle(1, 1, 32'h10);
        for (int i = 0; i < 21; i++) cycle(1, 0, 0);
        check("end_pc",  pc_out,   32'd96);
        check("end_fpc", rom_addr, 32'd100);
        cycle(0, 0, 0);
        check("end_fault",   {31'h0, fault},      32'h1);
        check("end_pending", {31'h0, inst_valid}, 32'h1);
        cycle(1, 0, 0);
        check("end_drained", {31'h0, inst_valid}, 32'h0);
        cycle(1, 1, 32'h0);
        check("fault_ignores_redirect", rom_addr, 32'd100);
        check("fault_sticky", {31'h0, fault}, 32'h1);

        // Misaligned redirect target
        @(negedge clk);
        reset_dut();
        cycle(1, 0, 0);
        cycle(1, 1, 32'h6);
        check("mis_nofault_yet", {31'h0, fault}, 32'h0);
        cycle(1, 0, 0);
        check("mis_fault", {31'h0, fault}, 32'h1);

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        reset_dut();
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        dec_ready = 1'b1;
        cycle(1, 0, 0);
        check("restart_inst", inst_out, 32'h20010005);
        check("restart_pc",   pc_out,   32'h0);

        // Randomized episodes
        for (int ep = 0; ep < 6; ep++) begin
            for (int a = 0; a < ROM_BYTES; a += 4)
                put_word(a, ($urandom_range(0, 9) == 0) ? {6'h3F, 26'($urandom)}
                                                        : {6'($urandom_range(0, 62)), 26'($urandom)});
            @(negedge clk);
            reset_dut();
            for (int c = 0; c < 80; c++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 7)       tgt = 32'($urandom_range(0, 24)) * 32'd4;
                else if (sel == 7) tgt = 32'($urandom_range(0, 96)) | 32'h1;
                else if (sel == 8) tgt = 32'hFFFFFFFC;
                else               tgt = 32'd100;
                cycle($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0, tgt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
